// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter
// Shares one single-port frame RAM between the edge-detection pipeline stages.
// One requester at a time owns the RAM port for a whole burst of up to
// MAX_BURST beats. After a winner is latched in IDLE, BURST issues one beat per
// cycle and DRAIN closes the burst with a done pulse.
//
// Build option: define FRAME_ARB_FIXED_PRIO_EN to make the lowest-index request
// always win, with no round-robin pointer. When it is left undefined (the
// default), arbitration is round-robin.
//
// Read data timing: mem_rdata is captured on the clock edge that ends a read
// beat's cycle. That gives rvalid/rdata one cycle after the beat, so the last
// rvalid of a read burst lines up with done.

module frame_mem_arbiter #(
    parameter int NUM_REQ   = 6,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    localparam int LEN_W    = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        beat,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic [NUM_REQ-1:0]        done,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Burst context latched at grant time
    state_t              r_state;
    logic [IDX_W-1:0]    r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_cnt;

    // Registered copies of every output
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_beat;
    logic [NUM_REQ-1:0]  r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REQ-1:0]  r_done;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

`ifndef FRAME_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W:0]      w_sum;
`endif

    // Per-requester views of the packed request buses
    logic [ADDR_W-1:0]   w_addr  [NUM_REQ];
    logic [LEN_W-1:0]    w_len   [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata [NUM_REQ];

    logic                w_any;
    logic [IDX_W-1:0]    w_winner;
    logic [NUM_REQ-1:0]  w_owner_oh;

    // Unpack each lane and normalise its length: 0 means one beat, and
    // anything above MAX_BURST is cut down to MAX_BURST.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            logic [LEN_W-1:0] w_len_raw;
            assign w_len_raw   = req_len[gi*LEN_W +: LEN_W];
            assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign w_len[gi]   = (w_len_raw == '0)                   ? LEN_W'(1) :
                                 (w_len_raw > LEN_W'(MAX_BURST))     ? LEN_W'(MAX_BURST) :
                                                                        w_len_raw;
        end
    endgenerate

    assign w_any      = |req;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

`ifdef FRAME_ARB_FIXED_PRIO_EN
    // Winner select: lowest asserted index wins (descending scan, last hit kept)
    always_comb begin
        w_winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_winner = IDX_W'(i);
            end
        end
    end
`else
    // Winner select: first asserted request at or after r_rr_ptr, wrapping
    always_comb begin
        w_winner = '0;
        w_sum    = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(off);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                w_winner = w_sum[IDX_W-1:0];
            end
        end
    end
`endif

    // Arbitration FSM: grant in IDLE, one beat per cycle in BURST, done in DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_beat      <= '0;
            r_rvalid    <= '0;
            r_rdata     <= '0;
            r_done      <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifndef FRAME_ARB_FIXED_PRIO_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            r_beat   <= '0;
            r_done   <= '0;
            r_rvalid <= '0;

            // A read beat issued last cycle returns its data on this edge
            if (r_mem_en && !r_mem_we) begin
                r_rvalid <= w_owner_oh;
                r_rdata  <= mem_rdata;
            end

            case (r_state)
                ST_IDLE: begin
                    r_gnt    <= '0;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (enable && w_any) begin
                        r_owner <= w_winner;
                        r_we    <= req_we[w_winner];
                        r_addr  <= w_addr[w_winner];
                        r_cnt   <= w_len[w_winner];
                        r_state <= ST_BURST;
`ifndef FRAME_ARB_FIXED_PRIO_EN
                        r_rr_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
`endif
                    end
                end

                ST_BURST: begin
                    r_gnt       <= w_owner_oh;
                    r_beat      <= w_owner_oh;
                    r_mem_en    <= 1'b1;
                    r_mem_we    <= r_we;
                    r_mem_addr  <= r_addr;
                    r_mem_wdata <= w_wdata[r_owner];
                    r_addr      <= r_addr + 1'b1;
                    r_cnt       <= r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    r_gnt    <= '0;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_done   <= w_owner_oh;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign beat      = r_beat;
    assign rvalid    = r_rvalid;
    assign rdata     = r_rdata;
    assign done      = r_done;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter
// Self-checking bench for frame_mem_arbiter. It uses directed table vectors,
// hand-written multi-cycle sequences and randomized bursts. The bursts are
// checked against an arbitration and memory model built from the block's
// timing rules. Honours FRAME_ARB_FIXED_PRIO_EN in the same way as the design.

module tb_frame_mem_arbiter;

    localparam int NR = 6;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int MB = 16;
    localparam int LW = 5;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [NR-1:0]      req;
    logic [NR-1:0]      req_we;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*LW-1:0]   req_len;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      gnt;
    logic [NR-1:0]      beat;
    logic [NR-1:0]      rvalid;
    logic [DW-1:0]      rdata;
    logic [NR-1:0]      done;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    // Per-lane stimulus, packed onto the DUT buses below
    logic [AW-1:0]      t_addr [NR];
    logic [LW-1:0]      t_len  [NR];
    logic [DW-1:0]      t_wd   [NR];

    // Environment RAM (combinational read of the presented address)
    logic [DW-1:0]      ram   [65536];
    bit                 ram_w [65536];

    // Expected memory contents and model state
    logic [DW-1:0]      exp_mem [logic [AW-1:0]];
    int                 m_rr  = 0;
    int                 n_cmp = 0;
    int                 n_err = 0;

    typedef struct {
        int            idx;
        logic          we;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] seed;
        int            exp_owner;
        int            exp_beats;
    } vec_t;

    vec_t tbl [7];
    int   rr_exp [4];

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = t_addr[i];
            req_len[i*LW +: LW]   = t_len[i];
            req_wdata[i*DW +: DW] = t_wd[i];
        end
    end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            16'h0020: return 8'h11;
            16'h0021: return 8'h22;
            16'h0022: return 8'h33;
            default:  return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    assign mem_rdata = ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            ram_w[mem_addr] <= 1'b1;
        end
    end

    frame_mem_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .beat      (beat),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return exp_mem.exists(a) ? exp_mem[a] : init_val(a);
    endfunction

    // Arbitration model: which requester should win given the request mask
    function automatic int model_pick(input logic [NR-1:0] m);
`ifdef FRAME_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) begin
            if (m[i]) return i;
        end
`else
        for (int o = 0; o < NR; o++) begin
            if (m[(m_rr + o) % NR]) return (m_rr + o) % NR;
        end
`endif
        return -1;
    endfunction

    function automatic int model_len(input logic [LW-1:0] l);
        if (l == '0) return 1;
        if (int'(l) > MB) return MB;
        return int'(l);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},       32'(gnt),       32'd0);
        chk({tag, ".beat"},      32'(beat),      32'd0);
        chk({tag, ".rvalid"},    32'(rvalid),    32'd0);
        chk({tag, ".rdata"},     32'(rdata),     32'd0);
        chk({tag, ".done"},      32'(done),      32'd0);
        chk({tag, ".mem_en"},    32'(mem_en),    32'd0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'd0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // Cycles in which no burst may be active
    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("idle.gnt",    32'(gnt),    32'd0);
            chk("idle.beat",   32'(beat),   32'd0);
            chk("idle.mem_en", 32'(mem_en), 32'd0);
            chk("idle.done",   32'(done),   32'd0);
            chk("idle.rvalid", 32'(rvalid), 32'd0);
        end
    endtask

    // Called at a negedge when the DUT will sample in IDLE at the next edge (k).
    // Checks cycles k..k+L+1 and returns at the negedge before edge k+L+2.
    task automatic run_burst(input int owner, input int nb, input logic [DW-1:0] seed,
                             input bit perturb);
        logic [NR-1:0] oh, s_req, s_we, exp_oh, exp_rv, exp_done;
        logic          s_en, we;
        logic [AW-1:0] a0, a;
        logic [AW-1:0] s_addr [NR];
        logic [LW-1:0] s_len  [NR];
        logic [DW-1:0] wd_last;
        bit            in_beat, in_rv;

        oh      = NR'(1) << owner;
        we      = req_we[owner];
        a0      = t_addr[owner];
        s_req   = req;
        s_we    = req_we;
        s_en    = enable;
        s_addr  = t_addr;
        s_len   = t_len;
        wd_last = '0;
        $display("burst owner=%0d %s addr=0x%04h beats=%0d", owner, we ? "write" : "read",
                 a0, nb);

        for (int c = 0; c <= nb + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            in_beat  = (c >= 1) && (c <= nb);
            in_rv    = !we && (c >= 2) && (c <= nb + 1);
            exp_oh   = in_beat ? oh : '0;
            exp_rv   = in_rv ? oh : '0;
            exp_done = (c == nb + 1) ? oh : '0;
            chk("gnt",    32'(gnt),    32'(exp_oh));
            chk("beat",   32'(beat),   32'(exp_oh));
            chk("mem_en", 32'(mem_en), 32'(in_beat));
            chk("rvalid", 32'(rvalid), 32'(exp_rv));
            chk("done",   32'(done),   32'(exp_done));
            if (in_beat) begin
                a = a0 + AW'(c - 1);
                chk("mem_we",   32'(mem_we),   32'(we));
                chk("mem_addr", 32'(mem_addr), 32'(a));
                if (we) begin
                    chk("mem_wdata", 32'(mem_wdata), 32'(wd_last));
                    exp_mem[a] = wd_last;
                end
            end
            if (in_rv) begin
                a = a0 + AW'(c - 2);
                chk("rdata", 32'(rdata), 32'(exp_rd(a)));
            end
            // Next write data for the owner; other lanes get noise
            for (int i = 0; i < NR; i++) t_wd[i] = DW'($urandom);
            wd_last     = seed + DW'(c);
            t_wd[owner] = wd_last;
            // Inputs other than wdata must be ignored while the burst runs
            if (perturb && c <= nb) begin
                req    = NR'($urandom);
                req_we = NR'($urandom);
                enable = 1'($urandom);
                for (int i = 0; i < NR; i++) begin
                    t_addr[i] = AW'($urandom);
                    t_len[i]  = LW'($urandom);
                end
            end
        end

        req    = s_req;
        req_we = s_we;
        enable = s_en;
        t_addr = s_addr;
        t_len  = s_len;
        m_rr   = (owner + 1) % NR;
    endtask

    // Model-driven step: grant if the model says one happens, else one idle cycle
    task automatic arb_and_run(input bit perturb, input logic [DW-1:0] seed);
        int w;
        if (enable && (req != '0)) begin
            w = model_pick(req);
            run_burst(w, model_len(t_len[w]), seed, perturb);
        end else begin
            idle_check(1);
        end
    endtask

    initial begin
        // Directed vectors: single requester each, so the winner is unambiguous
        tbl[0] = '{0, 1'b1, 16'h0010, 5'd4,  8'hA0, 0, 4};   // single write
        tbl[1] = '{2, 1'b0, 16'h0020, 5'd3,  8'h00, 2, 3};   // read of preloaded data
        tbl[2] = '{4, 1'b1, 16'h0100, 5'd0,  8'hC0, 4, 1};   // len 0 -> 1 beat
        tbl[3] = '{1, 1'b0, 16'h0200, 5'd20, 8'h00, 1, 16};  // len 20 -> 16 beats
        tbl[4] = '{3, 1'b1, 16'hFFFE, 5'd4,  8'hE0, 3, 4};   // address wrap write
        tbl[5] = '{5, 1'b0, 16'hFFFE, 5'd4,  8'h00, 5, 4};   // read back across wrap
        tbl[6] = '{0, 1'b0, 16'h0010, 5'd4,  8'h00, 0, 4};   // read back first write
`ifdef FRAME_ARB_FIXED_PRIO_EN
        rr_exp = '{0, 0, 0, 0};
`else
        rr_exp = '{0, 3, 0, 3};
`endif

        // Reset with every request asserted: nothing may be granted
        reset  = 1'b1;
        enable = 1'b1;
        req    = '1;
        req_we = '1;
        for (int i = 0; i < NR; i++) begin
            t_addr[i] = AW'(i * 256 + 3);
            t_len[i]  = 5'd3;
            t_wd[i]   = 8'hFF;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        req   = '0;
        idle_check(2);

        // Round-robin between two continuously held requesters
        req       = 6'b001001;
        req_we    = '0;
        t_len[0]  = 5'd2;
        t_len[3]  = 5'd2;
        t_addr[0] = 16'h0040;
        t_addr[3] = 16'h0080;
        for (int i = 0; i < 4; i++) run_burst(rr_exp[i], 2, 8'h00, 1'b0);

        // Table-driven directed bursts, issued back to back
        for (int i = 0; i < 7; i++) begin
            req                 = '0;
            req[tbl[i].idx]     = 1'b1;
            req_we[tbl[i].idx]  = tbl[i].we;
            t_addr[tbl[i].idx]  = tbl[i].addr;
            t_len[tbl[i].idx]   = tbl[i].len;
            run_burst(tbl[i].exp_owner, tbl[i].exp_beats, tbl[i].seed, 1'b0);
        end

        // Reset in the middle of a read burst, then the same request again
        req       = '0;
        req[1]    = 1'b1;
        req_we[1] = 1'b0;
        t_addr[1] = 16'h0300;
        t_len[1]  = 5'd8;
        @(posedge clk);
        @(negedge clk);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_reset.beat", 32'(beat),     32'(6'b000010));
        chk("pre_reset.addr", 32'(mem_addr), 32'h0302);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("mid_reset");
        reset = 1'b0;
        m_rr  = 0;
        run_burst(1, 8, 8'h00, 1'b0);

        // enable low blocks new grants; raising it grants on the next edge
        enable    = 1'b0;
        req       = '0;
        req[5]    = 1'b1;
        req_we[5] = 1'b1;
        t_addr[5] = 16'h0500;
        t_len[5]  = 5'd5;
        idle_check(10);
        enable = 1'b1;
        run_burst(5, 5, 8'h50, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 60; n++) begin
            req    = NR'($urandom);
            enable = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NR; i++) begin
                req_we[i] = 1'($urandom);
                t_addr[i] = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + AW'($urandom_range(0, 7))
                                                          : AW'($urandom);
                t_len[i]  = LW'($urandom_range(0, 20));
            end
            arb_and_run(1'b1, DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
